// File: rtl/send_capture.sv
// -----------------------------------------------------------------------------
// send_capture
//
// Streams one capture frame to a UART transmitter through a four-phase
// fresh/taken handshake. A frame is a fixed seven-byte header (sync byte,
// sampling rate, trigger edge, threshold, pattern length, pattern, sample
// count) followed by N bytes read from an external synchronous sample buffer.
//
// Optional feature: define SEND_CAPTURE_CHECKSUM_EN to append one trailing
// byte holding the XOR of every preceding frame byte. Without the macro the
// frame ends after the last sample and no checksum logic is built.
//
// Parameters
//   SYNC_BYTE      first byte of every frame
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle frame request, honoured only when idle
//   configuration  {sampling_rate[7:0], trigger_edge, threshold[7:0],
//                   pattern_len[3:0], pattern[7:0]}
//   start_addr     buffer address of the first sample
//   sample_count   samples to send, 0 means 256
//   rd_addr        buffer read address
//   rd_data        buffer data, valid one cycle after rd_addr
//   tx_data        byte offered to the transmitter
//   tx_data_fresh  tx_data valid (level)
//   tx_data_taken  transmitter acknowledge (level)
//   busy           frame in progress
//   done           one-cycle pulse after the last byte is released
// -----------------------------------------------------------------------------
module send_capture #(
    parameter logic [7:0] SYNC_BYTE = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [28:0] configuration,
    input  logic [7:0]  start_addr,
    input  logic [7:0]  sample_count,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_data_fresh,
    input  logic        tx_data_taken,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] HDR_BYTES = 9'd7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        OFFER,
        RELEASE,
        DONE
    } state_e;

    state_e      state_q,   state_d;
    logic [28:0] cfg_q,     cfg_d;
    logic [7:0]  count_q,   count_d;
    logic [8:0]  pos_q,     pos_d;      // index of the byte being sent
    logic [7:0]  rd_addr_q, rd_addr_d;  // address of the next sample to fetch
    logic [7:0]  tx_data_q, tx_data_d;
    logic [8:0]  n_samples;
    logic [8:0]  last_pos;
    logic [7:0]  hdr_byte;
`ifdef SEND_CAPTURE_CHECKSUM_EN
    logic [7:0]  csum_q,    csum_d;
`endif

    assign n_samples = (count_q == 8'd0) ? 9'd256 : {1'b0, count_q};

`ifdef SEND_CAPTURE_CHECKSUM_EN
    assign last_pos = HDR_BYTES + n_samples;          // checksum follows samples
`else
    assign last_pos = HDR_BYTES + n_samples - 9'd1;   // last sample ends frame
`endif

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        hdr_byte = SYNC_BYTE;
        case (pos_q[2:0])
            3'd1:    hdr_byte = cfg_q[28:21];
            3'd2:    hdr_byte = {7'b0, cfg_q[20]};
            3'd3:    hdr_byte = cfg_q[19:12];
            3'd4:    hdr_byte = {4'b0, cfg_q[11:8]};
            3'd5:    hdr_byte = cfg_q[7:0];
            3'd6:    hdr_byte = count_q;
            default: hdr_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        count_d   = count_q;
        pos_d     = pos_q;
        rd_addr_d = rd_addr_q;
        tx_data_d = tx_data_q;
`ifdef SEND_CAPTURE_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d     = configuration;
                    count_d   = sample_count;
                    rd_addr_d = start_addr;
                    pos_d     = 9'd0;
`ifdef SEND_CAPTURE_CHECKSUM_EN
                    csum_d    = 8'h00;
`endif
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (pos_q < HDR_BYTES) begin
                    tx_data_d = hdr_byte;
                    state_d   = OFFER;
`ifdef SEND_CAPTURE_CHECKSUM_EN
                end else if (pos_q == last_pos) begin
                    tx_data_d = csum_q;
                    state_d   = OFFER;
`endif
                end else begin
                    // rd_addr already holds this sample's address, so the
                    // buffer sees it during LOAD and answers during FETCH.
                    state_d = FETCH;
                end
            end
            FETCH: begin
                tx_data_d = rd_data;
                rd_addr_d = rd_addr_q + 8'd1;   // wraps FF -> 00
                state_d   = OFFER;
            end
            OFFER: begin
                if (tx_data_taken) begin
`ifdef SEND_CAPTURE_CHECKSUM_EN
                    csum_d  = csum_q ^ tx_data_q;
`endif
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!tx_data_taken) begin
                    if (pos_q == last_pos) begin
                        state_d = DONE;
                    end else begin
                        pos_d   = pos_q + 9'd1;
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            count_q   <= '0;
            pos_q     <= '0;
            rd_addr_q <= '0;
            tx_data_q <= '0;
`ifdef SEND_CAPTURE_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            count_q   <= count_d;
            pos_q     <= pos_d;
            rd_addr_q <= rd_addr_d;
            tx_data_q <= tx_data_d;
`ifdef SEND_CAPTURE_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign rd_addr       = rd_addr_q;
    assign tx_data       = tx_data_q;
    assign tx_data_fresh = (state_q == OFFER);
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);

endmodule
